// File: rtl/imem_boot_loader_if.sv
// Instruction stream handshake between a program source and imem_boot_loader.
// The master drives words with S_VALID/S_DATA and the loader accepts them through S_READY.
interface imem_boot_loader_if #(
    parameter int DATA_W = 32
);
    logic              S_VALID;
    logic [DATA_W-1:0] S_DATA;
    logic              S_READY;

    modport master (
        output S_VALID,
        output S_DATA,
        input  S_READY
    );

    modport slave (
        input  S_VALID,
        input  S_DATA,
        output S_READY
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Streams machine-code words into instruction memory and holds the CPU in reset until the load settles.
// Optional macro IMEM_ZERO_FILL_EN: pad the memory above the program with nops before releasing the CPU.
//
// state | meaning
// IDLE  | after reset, CPU held in reset, waiting for LOAD_START
// LOAD  | accepting stream words, one write per accepted word
// FILL  | (IMEM_ZERO_FILL_EN only) writing zeros from LOAD_LEN up to the top of memory
// HOLD  | CPU still in reset for RESET_HOLD cycles after the last write
// RUN   | CPU released; a legal LOAD_START reloads
module imem_boot_loader #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int RESET_HOLD = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                LOAD_START,
    input  logic [ADDR_W:0]     LOAD_LEN,
    imem_boot_loader_if.slave   s_if,
    output logic                IMEM_WE,
    output logic [ADDR_W-1:0]   IMEM_ADDR,
    output logic [DATA_W-1:0]   IMEM_WDATA,
    output logic                CPU_RSTn,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR
);
    localparam logic [ADDR_W:0] DEPTH  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};
    localparam int              HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
`ifdef IMEM_ZERO_FILL_EN
        ST_FILL = 3'd2,
`endif
        ST_HOLD = 3'd3,
        ST_RUN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cpu_rstn_q, cpu_rstn_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [ADDR_W:0]     cnt_inc;
    logic                len_ok;

    assign cnt_inc = cnt_q + ONE;
    assign len_ok  = (LOAD_LEN != '0) && (LOAD_LEN <= DEPTH);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cpu_rstn_d = cpu_rstn_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (LOAD_START) begin
                    if (len_ok) begin
                        state_d    = ST_LOAD;
                        cnt_d      = '0;
                        len_d      = LOAD_LEN;
                        cpu_rstn_d = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (s_if.S_VALID) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = s_if.S_DATA;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
`ifdef IMEM_ZERO_FILL_EN
                        if (len_q != DEPTH) begin
                            state_d = ST_FILL;
                        end else begin
                            state_d = ST_HOLD;
                            hold_d  = HOLD_INIT;
                        end
`else
                        state_d = ST_HOLD;
                        hold_d  = HOLD_INIT;
`endif
                    end
                end
            end
`ifdef IMEM_ZERO_FILL_EN
            ST_FILL: begin
                we_d    = 1'b1;
                addr_d  = cnt_q[ADDR_W-1:0];
                wdata_d = '0;
                cnt_d   = cnt_inc;
                if (cnt_inc == DEPTH) begin
                    state_d = ST_HOLD;
                    hold_d  = HOLD_INIT;
                end
            end
`endif
            ST_HOLD: begin
                // hold counter is loaded on entry, so HOLD lasts exactly RESET_HOLD cycles
                if (hold_q == '0) begin
                    state_d    = ST_RUN;
                    cpu_rstn_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    hold_d = hold_q - HOLD_ONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_RUN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            len_q      <= '0;
            hold_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cpu_rstn_q <= cpu_rstn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign s_if.S_READY = (state_q == ST_LOAD);
    assign IMEM_WE      = we_q;
    assign IMEM_ADDR    = addr_q;
    assign IMEM_WDATA   = wdata_q;
    assign CPU_RSTn     = cpu_rstn_q;
    assign BUSY         = busy_q;
    assign DONE         = done_q;
    assign ERR          = err_q;
endmodule
